// File: rtl/mips_timing_pkg.sv
// Phase constants shared by the sequencer and the pipeline-stage registers,
// plus the sequencer state encoding.
package mips_timing_pkg;

  localparam int unsigned FETCH_PHASE = 17;
  localparam int unsigned EXEC_PHASE  = 20;
  localparam int unsigned MEM_PHASE   = 24;
  localparam int unsigned WB_PHASE    = 28;
  localparam int unsigned LAST_PHASE  = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_IMEM,
    ST_WAIT_DMEM,
    ST_HALTED
  } seq_state_t;

endpackage

// File: rtl/cycle_sequencer_if.sv
// Control/handshake bundle between the core and its phase sequencer.
// Handshake: imem_req/dmem_req are levels held until the matching *_ready is
// seen high in the same cycle; a transfer happens only when req && ready.
interface cycle_sequencer_if;
  logic        run;
  logic        halt_req;
  logic        imem_ready;
  logic        dmem_ready;
  logic        is_mem_op;
  logic [4:0]  timehandler;
  logic        imem_req;
  logic        dmem_req;
  logic        fetch_en;
  logic        exec_en;
  logic        mem_en;
  logic        wb_en;
  logic        pc_en;
  logic        busy;
  logic        halted;
  logic [31:0] inst_count;

  modport master (
    output run, halt_req, imem_ready, dmem_ready, is_mem_op,
    input  timehandler, imem_req, dmem_req, fetch_en, exec_en, mem_en,
           wb_en, pc_en, busy, halted, inst_count
  );

  modport slave (
    input  run, halt_req, imem_ready, dmem_ready, is_mem_op,
    output timehandler, imem_req, dmem_req, fetch_en, exec_en, mem_en,
           wb_en, pc_en, busy, halted, inst_count
  );
endinterface

// File: rtl/cycle_sequencer.sv
// Multi-cycle core phase sequencer: owns the timehandler phase counter, stalls
// on memory readiness, decodes stage strobes and stops at instruction boundaries.
module cycle_sequencer
  import mips_timing_pkg::*;
#(
  parameter int unsigned P_FETCH = FETCH_PHASE,
  parameter int unsigned P_EXEC  = EXEC_PHASE,
  parameter int unsigned P_MEM   = MEM_PHASE,
  parameter int unsigned P_WB    = WB_PHASE,
  parameter int unsigned P_LAST  = LAST_PHASE
) (
  input  logic               clk,
  input  logic               rst,
  cycle_sequencer_if.slave   bus,
  output seq_state_t         seq_state
);

  if (!(P_FETCH > 0 && P_FETCH < P_EXEC && P_EXEC < P_MEM &&
        P_MEM < P_WB && P_WB < P_LAST && P_LAST <= 31)) begin : g_phase_check
    $error("cycle_sequencer: phase constants must be strictly increasing within 1..31");
  end

  localparam logic [4:0] FETCH_P = 5'(P_FETCH);
  localparam logic [4:0] EXEC_P  = 5'(P_EXEC);
  localparam logic [4:0] MEM_P   = 5'(P_MEM);
  localparam logic [4:0] WB_P    = 5'(P_WB);
  localparam logic [4:0] LAST_P  = 5'(P_LAST);

  seq_state_t  state;
  logic [4:0]  th;
  logic [31:0] inst_count;
  logic        halt_pending;

  logic in_run;
  assign in_run = (state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      th           <= 5'd0;
      inst_count   <= 32'd0;
      halt_pending <= 1'b0;
    end else begin
      // Sticky halt only while the core is actually executing.
      if (bus.halt_req && state != ST_IDLE && state != ST_HALTED)
        halt_pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.run) begin
            state <= ST_RUN;
            th    <= 5'd0;
          end
        end
        ST_RUN: begin
          if (th == 5'd0) begin
            if (bus.imem_ready) th    <= 5'd1;
            else                state <= ST_WAIT_IMEM;
          end else if (th == MEM_P && bus.is_mem_op && !bus.dmem_ready) begin
            state <= ST_WAIT_DMEM;
          end else if (th == LAST_P) begin
            inst_count <= inst_count + 32'd1;
            th         <= 5'd0;
            if (halt_pending || bus.halt_req) state <= ST_HALTED;
          end else begin
            th <= th + 5'd1;
          end
        end
        ST_WAIT_IMEM: begin
          if (bus.imem_ready) begin
            state <= ST_RUN;
            th    <= 5'd1;
          end
        end
        ST_WAIT_DMEM: begin
          if (bus.dmem_ready) begin
            state <= ST_RUN;
            th    <= MEM_P + 5'd1;
          end
        end
        ST_HALTED: th <= 5'd0;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Requests and strobes are decoded from registered state so reset drops them at once.
  assign bus.imem_req = (in_run && th == 5'd0) || (state == ST_WAIT_IMEM);
  assign bus.dmem_req = (in_run && th == MEM_P && bus.is_mem_op) || (state == ST_WAIT_DMEM);
  assign bus.mem_en   = (in_run && th == MEM_P && (!bus.is_mem_op || bus.dmem_ready)) ||
                        (state == ST_WAIT_DMEM && bus.dmem_ready);
  assign bus.fetch_en = in_run && th == FETCH_P;
  assign bus.exec_en  = in_run && th == EXEC_P;
  assign bus.wb_en    = in_run && th == WB_P;
  assign bus.pc_en    = in_run && th == LAST_P;

  assign bus.busy        = in_run || state == ST_WAIT_IMEM || state == ST_WAIT_DMEM;
  assign bus.halted      = (state == ST_HALTED);
  assign bus.timehandler = th;
  assign bus.inst_count  = inst_count;
  assign seq_state       = state;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: inputs change just after the falling
// edge and outputs are sampled 1ns later, half a period away from posedge.
module tb_cycle_sequencer;
  import mips_timing_pkg::*;

  logic       clk;
  logic       rst;
  seq_state_t seq_state;
  int         errors;
  int         checks;

  cycle_sequencer_if bus ();

  cycle_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .seq_state (seq_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_defaults();
    bus.run        = 1'b0;
    bus.halt_req   = 1'b0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    bus.is_mem_op  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_defaults();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Leaves the bench at a falling edge with the DUT in RUN, phase 0.
  task automatic start_run();
    @(negedge clk);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] strobes;
    rst = 1'b1;
    set_defaults();
    @(negedge clk);
    #1;
    strobes = {bus.imem_req, bus.dmem_req, bus.fetch_en, bus.exec_en,
               bus.mem_en, bus.wb_en, bus.pc_en, bus.busy};
    checks++;
    if (bus.timehandler !== 5'd0 || bus.inst_count !== 32'd0 || seq_state !== ST_IDLE || strobes !== 8'd0) begin
      errors++;
      $display("FAIL reset_init: th=%0d cnt=%0d state=%0d strobes=%b, want 0/0/IDLE/0",
               bus.timehandler, bus.inst_count, seq_state, strobes);
    end
    @(negedge clk);
    rst = 1'b0;
    start_run();
    for (int c = 0; c < 10; c++) @(negedge clk);
    #1;
    checks++;
    if (bus.timehandler !== 5'd10) begin
      errors++;
      $display("FAIL reset_pre_phase: th=%0d want 10", bus.timehandler);
    end
    #1;
    rst = 1'b1;
    #1;
    strobes = {bus.imem_req, bus.dmem_req, bus.fetch_en, bus.exec_en,
               bus.mem_en, bus.wb_en, bus.pc_en, bus.busy};
    checks++;
    if (bus.timehandler !== 5'd0 || bus.inst_count !== 32'd0 || seq_state !== ST_IDLE || strobes !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: th=%0d cnt=%0d state=%0d strobes=%b, want 0/0/IDLE/0",
               bus.timehandler, bus.inst_count, seq_state, strobes);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [5:0] got;
    logic [5:0] exp;
    int         ph;
    do_reset();
    start_run();
    for (int c = 0; c <= 96; c++) begin
      ph = c % 32;
      #1;
      got = {bus.fetch_en, bus.exec_en, bus.mem_en, bus.wb_en, bus.pc_en, bus.imem_req};
      exp = {ph == 17, ph == 20, ph == 24, ph == 28, ph == 31, ph == 0};
      checks++;
      if (bus.timehandler !== 5'(ph) || got !== exp) begin
        errors++;
        $display("FAIL basic_cycle%0d: th=%0d strobes=%b, want th=%0d strobes=%b",
                 c, bus.timehandler, got, ph, exp);
      end
      if (c == 32 || c == 64 || c == 96) begin
        checks++;
        if (bus.inst_count !== 32'(c / 32)) begin
          errors++;
          $display("FAIL basic_count%0d: inst_count=%0d want %0d", c, bus.inst_count, c / 32);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_imem_stall();
    int ph;
    do_reset();
    bus.imem_ready = 1'b0;
    start_run();
    for (int c = 0; c <= 37; c++) begin
      bus.imem_ready = (c >= 5);
      ph = (c <= 5) ? 0 : (c - 5) % 32;
      #1;
      checks++;
      if (bus.timehandler !== 5'(ph) || bus.imem_req !== (c <= 5 || c == 37) ||
          bus.fetch_en !== (c == 22) || bus.pc_en !== (c == 36)) begin
        errors++;
        $display("FAIL imem_stall_cycle%0d: th=%0d req=%b fetch=%b pc=%b, want th=%0d",
                 c, bus.timehandler, bus.imem_req, bus.fetch_en, bus.pc_en, ph);
      end
      if (c == 37) begin
        checks++;
        if (bus.inst_count !== 32'd1) begin
          errors++;
          $display("FAIL imem_stall_period: inst_count=%0d want 1", bus.inst_count);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_dmem_stall();
    int ph;
    do_reset();
    bus.is_mem_op = 1'b1;
    start_run();
    for (int c = 0; c <= 34; c++) begin
      bus.dmem_ready = (c == 27);
      ph = (c <= 24) ? c : (c <= 27 ? 24 : c - 3);
      #1;
      checks++;
      if (bus.timehandler !== 5'(ph) || bus.dmem_req !== (c >= 24 && c <= 27) ||
          bus.mem_en !== (c == 27) || bus.wb_en !== (c == 31)) begin
        errors++;
        $display("FAIL dmem_stall_cycle%0d: th=%0d dreq=%b mem=%b wb=%b, want th=%0d",
                 c, bus.timehandler, bus.dmem_req, bus.mem_en, bus.wb_en, ph);
      end
      if (c == 26) begin
        checks++;
        if (seq_state !== ST_WAIT_DMEM) begin
          errors++;
          $display("FAIL dmem_stall_state: state=%0d want %0d", seq_state, ST_WAIT_DMEM);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt(input int halt_cycle, input string name);
    do_reset();
    start_run();
    for (int c = 0; c <= 31; c++) begin
      bus.halt_req = (c == halt_cycle);
      #1;
      if (c == 31) begin
        checks++;
        if (bus.pc_en !== 1'b1 || bus.halted !== 1'b0) begin
          errors++;
          $display("FAIL %s_pc: pc_en=%b halted=%b want 1/0", name, bus.pc_en, bus.halted);
        end
      end
      @(negedge clk);
    end
    bus.halt_req = 1'b0;
    #1;
    checks++;
    if (bus.halted !== 1'b1 || bus.timehandler !== 5'd0 || bus.inst_count !== 32'd1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_stop: halted=%b th=%0d cnt=%0d busy=%b want 1/0/1/0",
               name, bus.halted, bus.timehandler, bus.inst_count, bus.busy);
    end
    @(negedge clk);
    bus.run = 1'b1;
    bus.is_mem_op = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 ||
        bus.mem_en !== 1'b0 || bus.timehandler !== 5'd0) begin
      errors++;
      $display("FAIL %s_run_ignored: halted=%b ireq=%b dreq=%b mem=%b th=%0d",
               name, bus.halted, bus.imem_req, bus.dmem_req, bus.mem_en, bus.timehandler);
    end
  endtask

  task automatic test_halt_idle();
    do_reset();
    @(negedge clk);
    bus.halt_req = 1'b1;
    @(negedge clk);
    bus.halt_req = 1'b0;
    #1;
    checks++;
    if (seq_state !== ST_IDLE || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_idle_state: state=%0d halted=%b want IDLE/0", seq_state, bus.halted);
    end
    start_run();
    for (int c = 0; c < 32; c++) @(negedge clk);
    #1;
    checks++;
    if (bus.halted !== 1'b0 || bus.busy !== 1'b1 || bus.timehandler !== 5'd0 ||
        bus.inst_count !== 32'd1 || bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL halt_idle_run: halted=%b busy=%b th=%0d cnt=%0d ireq=%b want 0/1/0/1/1",
               bus.halted, bus.busy, bus.timehandler, bus.inst_count, bus.imem_req);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_imem_stall();
    test_dmem_stall();
    test_halt(5, "halt_mid");
    test_halt(31, "halt_last");
    test_halt_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Phase sequencer for the multi-cycle MIPS core. It owns the 5-bit `timehandler` phase counter that the pipeline-stage registers decode, including fetch-result latching at phase 17. It issues instruction and data memory requests, holds the phase while memory is not ready, emits one-cycle stage strobes, and stops the core cleanly on a halt request at an instruction boundary.

## Interface
- `FETCH_PHASE`, 17: phase in which fetch results are latched.
- `EXEC_PHASE`, 20: execute strobe phase.
- `MEM_PHASE`, 24: data-memory phase; the counter can stall here.
- `WB_PHASE`, 28: register writeback strobe phase.
- `LAST_PHASE`, 31: final phase; PC update and wrap to 0.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `run` in 1: start pulse, honoured only in IDLE.
- `halt_req` in 1: halt request pulse, captured sticky.
- `imem_ready` in 1: instruction memory has data this cycle.
- `dmem_ready` in 1: data memory access completes this cycle.
- `is_mem_op` in 1: decoded instruction is a load or store; valid from `FETCH_PHASE`+1 onward.
- `timehandler` out 5: current phase.
- `imem_req` out 1: instruction fetch request (level).
- `dmem_req` out 1: data access request (level).
- `fetch_en`, `exec_en`, `mem_en`, `wb_en`, `pc_en` out 1 each: stage strobes.
- `busy` out 1: high in RUN, WAIT_IMEM and WAIT_DMEM.
- `halted` out 1: high in HALTED.
- `inst_count` out 32: retired instruction count.

## Operation
- States are IDLE, RUN, WAIT_IMEM, WAIT_DMEM and HALTED.
- **Reset.** State is IDLE. `timehandler`=0, `inst_count`=0, halt_pending=0, and every strobe and request is 0.
- **IDLE.** When `run`=1, go to RUN with `timehandler`=0. Otherwise hold.
- **RUN, phase 0.**
  - `imem_req`=1.
  - If `imem_ready`=1, advance to phase 1.
  - Otherwise go to WAIT_IMEM, holding phase 0.
- **WAIT_IMEM.**
  - `imem_req` stays 1.
  - On `imem_ready`=1, return to RUN at phase 1.
- **RUN, other phases.** `timehandler` increments by 1 each cycle.
- **MEM_PHASE with `is_mem_op`=1.**
  - `dmem_req`=1.
  - If `dmem_ready`=1, `mem_en`=1 and the phase advances.
  - Otherwise go to WAIT_DMEM, holding `MEM_PHASE`.
- **WAIT_DMEM.**
  - `dmem_req` stays 1.
  - On `dmem_ready`=1, `mem_en`=1 for exactly that cycle, then return to RUN at `MEM_PHASE`+1.
- **MEM_PHASE with `is_mem_op`=0.** `mem_en`=1 for one cycle and there is no stall.
- **Stage strobes.** `fetch_en`, `exec_en`, `wb_en` and `pc_en` are each 1 exactly when in RUN and `timehandler` equals the respective phase: FETCH, EXEC, WB and LAST.
- **LAST_PHASE.**
  - `inst_count` increments, wrapping modulo 2^32.
  - `timehandler` wraps to 0.
  - If halt_pending=1, or `halt_req`=1 in the same cycle, go to HALTED instead of phase 0.
- **halt_req.** Sets halt_pending in any state except IDLE and HALTED. It is ignored in IDLE.
- **HALTED.** `timehandler`=0 and all strobes and requests are 0. `run` is ignored. Only `rst` exits this state.
- **Static parameter check.** Require 0 < FETCH < EXEC < MEM < WB < LAST ≤ 31; fail elaboration otherwise.

## Timing
- All state, `timehandler` and `inst_count` are registers. Strobes and requests are decoded from registered state plus the `*_ready` and `is_mem_op` inputs only.
- Unstalled instruction period is LAST_PHASE+1 = 32 cycles. Each ready-low cycle adds one cycle.
- `fetch_en` asserts 17 cycles after the phase-0 cycle in which `imem_ready` was 1.
- `rst` overrides everything asynchronously, including mid-stall; requests drop immediately.
- If `imem_ready`/`dmem_ready` are high while the request is low, they are ignored.

## Structure
- Shared package `mips_timing_pkg` holds:
  - the phase constants (FETCH 17, EXEC 20, MEM 24, WB 28, LAST 31), shared with the stage registers;
  - the `seq_state_t` enum.
- The block is a single module with no sub-modules. The counter and FSM are tightly coupled.

## Test plan
- Reset during RUN at phase 10 (assert `rst`) → `timehandler`=0, IDLE, `inst_count`=0, all strobes 0 in the same cycle.
- `run` pulse, `imem_ready`=1, `is_mem_op`=0, 3 instructions:
  - `fetch_en` at phase 17, `exec_en` at 20, `mem_en` at 24, `wb_en` at 28, `pc_en` at 31;
  - `inst_count`=3 after 96 cycles;
  - 31→0 wrap each time.
- `imem_ready` low for 5 cycles at phase 0 → `timehandler` held at 0 with `imem_req`=1 throughout; instruction period 37.
- `is_mem_op`=1, `dmem_ready` high only on the 4th cycle at phase 24:
  - held at 24 for 3 extra cycles with `dmem_req`=1;
  - `mem_en` is a single pulse;
  - `wb_en` 4 cycles after release.
- `halt_req` pulse at phase 5 → instruction completes with `pc_en` at 31, `inst_count`+1, then `halted`=1, `timehandler`=0; a later `run` pulse is ignored.
- `halt_req` in the phase-31 cycle → HALTED at that boundary.
- `halt_req` in IDLE → ignored; the next `run` executes normally.
